// File: rtl/seg_display_scan.sv
// 8-digit multiplexed 7-segment scanner for the CPU syscall display word and performance counters.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module seg_display_scan #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter int          NUM_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_cpu_enable,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] uncondi_branch_num,
  input  logic [31:0] bubble_num,
  input  logic [2:0]  disp_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pre_cnt;
  logic [2:0]  digit_q;
  logic [31:0] data_q;
  logic [31:0] snap_q;
  logic        seen_q;
  logic [7:0]  an_q, seg_q;

  logic        tick;
  logic        frame_start;
  logic        sel_syscall;
  logic [31:0] sel_word;
  logic [3:0]  nibble;
  logic        dp_n;
  logic [7:0]  an_d, seg_d;

  assign tick        = (pre_cnt == REFRESH_DIV - 16'd1);
  assign frame_start = (state_q == S_BLANK) && (digit_q == 3'd0);
  assign sel_syscall = (disp_sel == 3'd0) || (disp_sel >= 3'd5);
  assign nibble      = snap_q[{digit_q, 2'b00} +: 4];
  assign dp_n        = !((digit_q == 3'd0) && sel_syscall && seen_q);

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

  always_comb begin
    case (disp_sel)
      3'd1:    sel_word = total_cycles;
      3'd2:    sel_word = condi_branch_num;
      3'd3:    sel_word = uncondi_branch_num;
      3'd4:    sel_word = bubble_num;
      default: sel_word = data_q;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BLANK: state_d = S_SHOW;
      S_SHOW:  if (tick) state_d = S_BLANK;
      default: state_d = S_BLANK;
    endcase
  end

  // Output word for the current state; registered below for a glitch-free drive.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 8'hFF;
    if (state_q == S_SHOW) begin
      an_d  = ~(8'b1 << digit_q);
      seg_d = {dp_n, hex_font(nibble)};
`ifdef LEADING_ZERO_BLANK_EN
      if ((digit_q != 3'd0) && ((snap_q >> {digit_q, 2'b00}) == 32'd0))
        seg_d = 8'hFF;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BLANK;
      pre_cnt <= 16'd0;
      digit_q <= 3'd0;
      data_q  <= 32'd0;
      snap_q  <= 32'd0;
      seen_q  <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if ((state_q == S_SHOW) && tick)
        digit_q <= (digit_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
      if (led_cpu_enable) begin
        data_q <= led_data_in;
        seen_q <= 1'b1;
      end
      // Sampling only at frame start keeps a whole frame coherent.
      if (frame_start)
        snap_q <= sel_word;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan (REFRESH_DIV=4): timeline model plus directed literal checks.
`timescale 1ns/1ps
module tb_seg_display_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        led_cpu_enable;
  logic [31:0] led_data_in;
  logic [31:0] total_cycles;
  logic [31:0] condi_branch_num;
  logic [31:0] uncondi_branch_num;
  logic [31:0] bubble_num;
  logic [2:0]  disp_sel;
  logic [7:0]  an;
  logic [7:0]  seg;

  seg_display_scan #(.REFRESH_DIV(16'd4), .NUM_DIGITS(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .led_cpu_enable     (led_cpu_enable),
    .led_data_in        (led_data_in),
    .total_cycles       (total_cycles),
    .condi_branch_num   (condi_branch_num),
    .uncondi_branch_num (uncondi_branch_num),
    .bubble_num         (bubble_num),
    .disp_sel           (disp_sel),
    .an                 (an),
    .seg                (seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Timeline model: m_k counts non-reset clock edges since the last reset.
  logic [6:0]  font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_k = 0;
  int          m_pos, m_dig;
  logic [31:0] m_data, m_snap, m_nib;
  logic        m_seen, m_dp;
  logic [7:0]  exp_an = 8'hFF, exp_seg = 8'hFF;

  always @(posedge clk) begin
    if (rst) begin
      m_k = 0; m_data = 0; m_snap = 0; m_seen = 0;
      exp_an = 8'hFF; exp_seg = 8'hFF;
    end else begin
      m_pos = m_k % DIV;
      m_dig = (m_k / DIV) % 8;
      if (m_pos == 0) begin
        exp_an = 8'hFF; exp_seg = 8'hFF;
        if (m_dig == 0) begin
          case (disp_sel)
            3'd1:    m_snap = total_cycles;
            3'd2:    m_snap = condi_branch_num;
            3'd3:    m_snap = uncondi_branch_num;
            3'd4:    m_snap = bubble_num;
            default: m_snap = m_data;
          endcase
        end
      end else begin
        m_nib  = (m_snap >> (4 * m_dig)) & 32'hF;
        m_dp   = (m_dig == 0) && (disp_sel == 0 || disp_sel >= 5) && m_seen;
        exp_an = 8'hFF & ~(8'h01 << m_dig);
        exp_seg = {~m_dp, font_tab[m_nib[3:0]]};
`ifdef LEADING_ZERO_BLANK_EN
        if (m_dig > 0 && (m_snap >> (4 * m_dig)) == 0) exp_seg = 8'hFF;
`endif
      end
      if (led_cpu_enable) begin
        m_data = led_data_in;
        m_seen = 1'b1;
      end
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_an", an, exp_an);
      check("model_seg", seg, exp_seg);
    end
  end

  task automatic goto(input int target);
    int guard = 0;
    while (m_k != target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (m_k != target) check("goto_timeout", 8'(m_k), 8'(target));
  endtask

  task automatic strobe(input logic [31:0] v);
    led_cpu_enable = 1'b1;
    led_data_in    = v;
    @(negedge clk);
    led_cpu_enable = 1'b0;
  endtask

  logic [7:0] f1_seg [8] = '{8'h21, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  initial begin
    rst = 1'b1; led_cpu_enable = 1'b0; led_data_in = '0; disp_sel = 3'd0;
    total_cycles = 32'h0; condi_branch_num = 32'h22222222;
    uncondi_branch_num = 32'h3333_3333; bubble_num = 32'h4444_4444;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_an", an, 8'hFF);
    check("reset_seg", seg, 8'hFF);
    goto(2);
    check("first_show_an", an, 8'hFE);
    check("first_show_seg", seg, 8'hC0);

    // Syscall word shown on the following frame, dp lit on digit 0.
    goto(10);
    strobe(32'h1234ABCD);
    for (int d = 0; d < 8; d++) begin
      goto(FRAME + 4 * d + 2);
      check("f1_an", an, 8'hFF & ~(8'h01 << d));
      check("f1_seg", seg, f1_seg[d]);
      if (d == 3) begin
        disp_sel = 3'd1;
        total_cycles = 32'h0000_0010;
      end
    end

    // New source appears only at the next frame; later counter changes are ignored.
    goto(2 * FRAME + 2);
    check("sel1_d0", seg, 8'hC0);
    total_cycles = 32'hDEADBEEF;
    goto(2 * FRAME + 6);
    check("sel1_d1_an", an, 8'hFD);
    check("sel1_d1", seg, 8'hF9);

    goto(2 * FRAME + 16); disp_sel = 3'd2;
    goto(3 * FRAME + 16); disp_sel = 3'd3;
    goto(4 * FRAME + 16); disp_sel = 3'd4;
    goto(5 * FRAME + 16); disp_sel = 3'd6;
    goto(6 * FRAME + 2);
    check("alias6_d0", seg, 8'h21);

    // Strobe on a frame-start cycle lands one frame later.
    goto(7 * FRAME);
    strobe(32'hFFFF_FFFF);
    check("fs_strobe_d0_old", seg, 8'hFF);
    goto(7 * FRAME + 2);
    check("fs_strobe_cur", seg, 8'h21);
    goto(8 * FRAME + 2);
    check("all_f_d0", seg, 8'h0E);
    goto(8 * FRAME + 30);
    check("all_f_d7_an", an, 8'h7F);
    check("all_f_d7", seg, 8'h8E);

    // Reset during digit 5 restarts at a clean frame.
    disp_sel = 3'd0;
    goto(9 * FRAME + 22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_an", an, 8'hFF);
    goto(1);
    check("midrst_blank", an, 8'hFF);
    goto(2);
    check("midrst_show_an", an, 8'hFE);
    check("midrst_show_seg", seg, 8'hC0);

    // Leading-zero behaviour.
    goto(10);
    strobe(32'h0000_0A05);
    goto(FRAME + 2);  check("lz_d0", seg, 8'h12);
    goto(FRAME + 6);  check("lz_d1", seg, 8'hC0);
    goto(FRAME + 10); check("lz_d2", seg, 8'h88);
    goto(FRAME + 14);
    check("lz_d3_an", an, 8'hF7);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d3", seg, 8'hFF);
    goto(FRAME + 30); check("lz_d7", seg, 8'hFF);
`else
    check("lz_d3", seg, 8'hC0);
    goto(FRAME + 30); check("lz_d7", seg, 8'hC0);
`endif
    goto(2 * FRAME + 2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
